// File: rtl/timing_control_pkg.sv
// ---------------------------------------------------------------------------
// timing_control_pkg
// Shared constants for the basic-computer timing and control slice: data and
// counter widths, the opcode encoding held in IR[14:12], the timing step at
// which each instruction class finishes, and the IR bit that selects HLT.
// ---------------------------------------------------------------------------
package timing_control_pkg;

  localparam int DATA_W = 16;
  localparam int SC_W   = 4;
  localparam int OP_W   = 3;
  localparam int T_W    = 1 << SC_W;
  localparam int D_W    = 1 << OP_W;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_ADD   = 3'd1,
    OP_LDA   = 3'd2,
    OP_STA   = 3'd3,
    OP_BUN   = 3'd4,
    OP_BSA   = 3'd5,
    OP_ISZ   = 3'd6,
    OP_IOREG = 3'd7
  } opcode_t;

  // Last timing step of each instruction class; SC clears on the edge ending it.
  localparam logic [SC_W-1:0] T_END_AND_ADD_LDA = 4'd5;
  localparam logic [SC_W-1:0] T_END_STA_BUN     = 4'd4;
  localparam logic [SC_W-1:0] T_END_BSA         = 4'd5;
  localparam logic [SC_W-1:0] T_END_ISZ         = 4'd6;
  localparam logic [SC_W-1:0] T_END_IOREG       = 4'd3;

  // Step at which the instruction word is captured from memory.
  localparam logic [SC_W-1:0] T_FETCH = 4'd1;

  // B0 selects HLT among the register-reference instructions.
  localparam logic [3:0] HALT_BIT = 4'd0;

endpackage

// File: rtl/timing_control_if.sv
// ---------------------------------------------------------------------------
// timing_control_if
// Bundles the control-unit signals.
//   START, MEM_DATA            : driven by the master (sequencer / memory side)
//   T, D, I, r, p, B, RUN      : driven by the slave (timing_control)
// ---------------------------------------------------------------------------
interface timing_control_if;
  import timing_control_pkg::*;

  logic              START;
  logic [DATA_W-1:0] MEM_DATA;
  logic [T_W-1:0]    T;
  logic [D_W-1:0]    D;
  logic              I;
  logic              r;
  logic              p;
  logic [11:0]       B;
  logic              RUN;

  modport master (
    output START, MEM_DATA,
    input  T, D, I, r, p, B, RUN
  );

  modport slave (
    input  START, MEM_DATA,
    output T, D, I, r, p, B, RUN
  );

endinterface

// File: rtl/timing_control_decoder_n.sv
// ---------------------------------------------------------------------------
// decoder_n
// Parameterised binary-to-one-hot decoder.
//   sel    : N-bit binary index
//   en     : when low the output is all zeros
//   onehot : 2**N-bit one-hot result
// ---------------------------------------------------------------------------
module decoder_n #(
  parameter int N = 2
) (
  input  logic [N-1:0]        sel,
  input  logic                en,
  output logic [(1<<N)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/timing_control.sv
// ---------------------------------------------------------------------------
// timing_control
// Sequence counter, instruction register and run flag of the basic computer.
// Produces one-hot timing T0..T15, opcode decode D0..D7 and the register /
// I/O strobes used by the datapath control gates.
//   CLK    : rising-edge clock
//   RST_N  : asynchronous active-low reset
//   bus    : slave side of timing_control_if (START, MEM_DATA in;
//            T, D, I, r, p, B, RUN out)
// ---------------------------------------------------------------------------
module timing_control
  import timing_control_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  timing_control_if.slave   bus
);

  logic [SC_W-1:0]   sc;
  logic [DATA_W-1:0] ir;
  logic              s;
  logic [T_W-1:0]    t_vec;
  logic [D_W-1:0]    d_vec;
  opcode_t           op;
  logic              r_strobe;
  logic              p_strobe;
  logic              halt;
  logic              clr;

  assign op = opcode_t'(ir[14:12]);

  // Timing is gated by the run flag so T is all-zero while halted.
  decoder_n #(.N(SC_W)) t_decoder (
    .sel    (sc),
    .en     (s),
    .onehot (t_vec)
  );

  decoder_n #(.N(OP_W)) d_decoder (
    .sel    (op),
    .en     (1'b1),
    .onehot (d_vec)
  );

  assign r_strobe = d_vec[OP_IOREG] & ~ir[15] & t_vec[T_END_IOREG];
  assign p_strobe = d_vec[OP_IOREG] &  ir[15] & t_vec[T_END_IOREG];
  assign halt     = r_strobe & ir[HALT_BIT];

  // End-of-instruction detect; all end steps are past T2, so D is valid here.
  assign clr = ((d_vec[OP_AND] | d_vec[OP_ADD] | d_vec[OP_LDA]) & t_vec[T_END_AND_ADD_LDA])
             | ((d_vec[OP_STA] | d_vec[OP_BUN])                 & t_vec[T_END_STA_BUN])
             | (d_vec[OP_BSA]                                   & t_vec[T_END_BSA])
             | (d_vec[OP_ISZ]                                   & t_vec[T_END_ISZ])
             | (d_vec[OP_IOREG]                                 & t_vec[T_END_IOREG]);

  // Halt has priority over START; SC only advances while running and wraps mod 16.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sc <= '0;
      ir <= '0;
      s  <= 1'b0;
    end else if (halt) begin
      sc <= '0;
      s  <= 1'b0;
    end else if (!s) begin
      s <= bus.START;
    end else begin
      if (t_vec[T_FETCH]) ir <= bus.MEM_DATA;
      sc <= clr ? '0 : sc + SC_W'(1);
    end
  end

  assign bus.T   = t_vec;
  assign bus.D   = d_vec;
  assign bus.I   = ir[15];
  assign bus.r   = r_strobe;
  assign bus.p   = p_strobe;
  assign bus.B   = ir[11:0];
  assign bus.RUN = s;

endmodule
